// File: rtl/spgd_dac_arbiter.sv
// Round-robin arbiter sharing one parallel DAC write port among SPGD producers.
// Each granted word is driven through a setup/strobe/hold cycle and then acknowledged.
module spgd_dac_arbiter #(
  parameter int DAC_WIDTH  = 14,
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          ADC_CLK,
  input  logic                          RST_N,
  input  logic                          ARB_EN,
  input  logic [NUM_CH-1:0]             REQ,
  input  logic [NUM_CH*DAC_WIDTH-1:0]   REQ_DATA,
  output logic [NUM_CH-1:0]             ACK,
  output logic [DAC_WIDTH-1:0]          DAC_DATA,
  output logic [CH_WIDTH-1:0]           DAC_CH,
  output logic                          DAC_WRT,
  output logic                          BUSY,
  output logic [15:0]                   XFER_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [CNT_WIDTH-1:0] SETUP_LAST  = CNT_WIDTH'(SETUP_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] STROBE_LAST = CNT_WIDTH'(STROBE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYC - 1);
  localparam logic [CH_WIDTH-1:0]  LAST_RST    = CH_WIDTH'(NUM_CH - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CH_WIDTH-1:0]    last_q, last_d;
  logic [CH_WIDTH-1:0]    ch_q, ch_d;
  logic [DAC_WIDTH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]      ack_q, ack_d;
  logic                   wrt_q, wrt_d;
  logic                   busy_q, busy_d;
  logic [15:0]            xfer_q, xfer_d;

  logic [CH_WIDTH-1:0]    pick;
  logic                   found;
  logic                   fire;
  int                     idx;

  // Search starts just past the last winner so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = CH_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ch_d    = ch_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (ARB_EN && found) begin
          state_d = SETUP;
          cnt_d   = '0;
          last_d  = pick;
          ch_d    = pick;
          data_d  = REQ_DATA[int'(pick)*DAC_WIDTH +: DAC_WIDTH];
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they toggle on the state edge.
  always_comb begin
    wrt_d  = (state_d == STROBE);
    busy_d = (state_d != IDLE);
    fire   = (state_d == HOLD) && (cnt_d == HOLD_LAST);
    xfer_d = xfer_q + 16'(fire);
    ack_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_d[i] = fire && (ch_q == CH_WIDTH'(i));
    end
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      ch_q    <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      wrt_q   <= 1'b0;
      busy_q  <= 1'b0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      wrt_q   <= wrt_d;
      busy_q  <= busy_d;
      xfer_q  <= xfer_d;
    end
  end

  assign ACK      = ack_q;
  assign DAC_DATA = data_q;
  assign DAC_CH   = ch_q;
  assign DAC_WRT  = wrt_q;
  assign BUSY     = busy_q;
  assign XFER_CNT = xfer_q;

endmodule

// File: tb/tb_spgd_dac_arbiter.sv
// Bench for spgd_dac_arbiter: directed scenarios plus random levels,
// checked every cycle against a transfer-timeline reference model.
module tb_spgd_dac_arbiter;

  localparam int W   = 14;
  localparam int N   = 3;
  localparam int CW  = 2;
  localparam int S   = 2;
  localparam int ST  = 1;
  localparam int H   = 2;
  localparam int TOT = S + ST + H;

  logic            ADC_CLK;
  logic            RST_N;
  logic            ARB_EN;
  logic [N-1:0]    REQ;
  logic [N*W-1:0]  REQ_DATA;
  logic [N-1:0]    ACK;
  logic [W-1:0]    DAC_DATA;
  logic [CW-1:0]   DAC_CH;
  logic            DAC_WRT;
  logic            BUSY;
  logic [15:0]     XFER_CNT;

  int checks;
  int failures;

  bit          m_busy;
  int          m_age;
  int          m_last;
  int          m_ch;
  logic [W-1:0] m_data;
  logic [15:0] m_cnt;

  spgd_dac_arbiter dut (
    .ADC_CLK  (ADC_CLK),
    .RST_N    (RST_N),
    .ARB_EN   (ARB_EN),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .ACK      (ACK),
    .DAC_DATA (DAC_DATA),
    .DAC_CH   (DAC_CH),
    .DAC_WRT  (DAC_WRT),
    .BUSY     (BUSY),
    .XFER_CNT (XFER_CNT)
  );

  initial ADC_CLK = 1'b0;
  always #5 ADC_CLK = ~ADC_CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = N - 1;
    m_ch   = 0;
    m_data = '0;
    m_cnt  = '0;
  endtask

  // Timeline: grant edge is age 0; strobe covers ages S..S+ST-1, ACK at TOT-1.
  task automatic step();
    logic [N-1:0] exp_ack;
    if (m_busy) begin
      m_age++;
      if (m_age == TOT - 1) m_cnt = m_cnt + 16'd1;
      if (m_age == TOT) m_busy = 1'b0;
    end else if (ARB_EN && (REQ != '0)) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && REQ[(m_last + k) % N]) begin
          m_ch   = (m_last + k) % N;
          m_busy = 1'b1;
        end
      end
      m_last = m_ch;
      m_data = REQ_DATA[m_ch*W +: W];
      m_age  = 0;
    end
    @(posedge ADC_CLK);
    #1;
    exp_ack = '0;
    if (m_busy && m_age == TOT - 1) exp_ack[m_ch] = 1'b1;
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("wrt", 32'(DAC_WRT), 32'(m_busy && m_age >= S && m_age < S + ST));
    chk("ack", 32'(ACK), 32'(exp_ack));
    chk("ch", 32'(DAC_CH), 32'(m_ch));
    chk("data", 32'(DAC_DATA), 32'(m_data));
    chk("xfer", 32'(XFER_CNT), 32'(m_cnt));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ch < 0 matches any channel.
  task automatic run_until(input int ch, input int age);
    int n;
    n = 0;
    while (!(m_busy && m_age == age && (ch < 0 || m_ch == ch)) && n < 100) begin
      step();
      n++;
    end
    chk("wait_bound", 32'(n < 100), 32'd1);
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while (m_busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    ARB_EN   = 1'b0;
    REQ      = '0;
    REQ_DATA = '0;
    model_reset();
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_wrt", 32'(DAC_WRT), 32'd0);
    chk("rst_data", 32'(DAC_DATA), 32'd0);
    chk("rst_ch", 32'(DAC_CH), 32'd0);
    chk("rst_xfer", 32'(XFER_CNT), 32'd0);
    #12;
    RST_N  = 1'b1;
    ARB_EN = 1'b1;

    // Single request on channel 1.
    REQ = 3'b010;
    REQ_DATA[1*W +: W] = 14'h1A5C;
    step();
    chk("t1_ch", 32'(DAC_CH), 32'd1);
    chk("t1_data", 32'(DAC_DATA), 32'h1A5C);
    chk("t1_wrt0", 32'(DAC_WRT), 32'd0);
    step();
    step();
    chk("t1_wrt1", 32'(DAC_WRT), 32'd1);
    step();
    chk("t1_wrt2", 32'(DAC_WRT), 32'd0);
    step();
    chk("t1_ack", 32'(ACK), 32'b010);
    REQ = '0;
    step();
    chk("t1_idle", 32'(BUSY), 32'd0);
    chk("t1_cnt", 32'(XFER_CNT), 32'd1);

    // All channels requesting continuously.
    REQ = 3'b111;
    for (int c = 0; c < N; c++) REQ_DATA[c*W +: W] = W'($urandom);
    steps(54);
    chk("rr_cnt", 32'(XFER_CNT), 32'd10);
    REQ = '0;
    run_idle();

    // Data captured at grant; REQ drop mid-transfer does not abort.
    REQ = 3'b001;
    REQ_DATA[0 +: W] = 14'h0001;
    step();
    REQ_DATA[0 +: W] = 14'h3FFF;
    REQ = '0;
    steps(4);
    chk("cap_ack", 32'(ACK), 32'b001);
    chk("cap_data", 32'(DAC_DATA), 32'h0001);
    run_idle();
    REQ = 3'b100;
    run_until(2, S);
    REQ = '0;
    steps(2);
    chk("drop_ack", 32'(ACK), 32'b100);
    run_idle();

    // ARB_EN low during setup of channel 2 with channel 0 pending.
    REQ = 3'b100;
    run_until(2, 0);
    ARB_EN = 1'b0;
    REQ    = 3'b101;
    steps(4);
    chk("en_ack", 32'(ACK), 32'b100);
    REQ = 3'b001;
    steps(10);
    chk("en_hold", 32'(BUSY), 32'd0);
    ARB_EN = 1'b1;
    step();
    chk("en_ch", 32'(DAC_CH), 32'd0);
    chk("en_busy", 32'(BUSY), 32'd1);
    run_idle();

    // Asynchronous reset in the middle of the strobe.
    REQ = 3'b111;
    run_until(-1, S);
    chk("ar_pre", 32'(DAC_WRT), 32'd1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("ar_wrt", 32'(DAC_WRT), 32'd0);
    chk("ar_ack", 32'(ACK), 32'd0);
    chk("ar_busy", 32'(BUSY), 32'd0);
    chk("ar_xfer", 32'(XFER_CNT), 32'd0);
    model_reset();
    #2;
    RST_N = 1'b1;
    step();
    chk("ar_first", 32'(DAC_CH), 32'd0);
    REQ = '0;
    run_idle();

    // Transfer counter wrap.
    force dut.xfer_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.xfer_q;
    step();
    chk("wrap_pre", 32'(XFER_CNT), 32'hFFFF);
    REQ = 3'b010;
    step();
    REQ = '0;
    run_idle();
    chk("wrap", 32'(XFER_CNT), 32'h0000);

    // Random levels, data and enable.
    for (int i = 0; i < 800; i++) begin
      REQ      = N'($urandom);
      ARB_EN   = ($urandom_range(0, 7) != 0);
      REQ_DATA = {W'($urandom), W'($urandom), W'($urandom)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spgd_dac_arbiter.md
Name: spgd_dac_arbiter

Overview:
Shares the single parallel DAC write port among the SPGD value producers: U+dU probe, U-dU probe and final U update. A round-robin arbiter grants one pending request at a time. A small state machine then drives a setup/strobe/hold write cycle and acknowledges the requester. It sits between the SPGD sequencing FSM/math registers and the DAC pins, replacing the direct DAC_SEL multiplexing.

Parameters:
DAC_WIDTH, 14, DAC data word width
NUM_CH, 3, number of requesters (2..4)
CH_WIDTH, 2, channel index width, must satisfy 2^CH_WIDTH >= NUM_CH
SETUP_CYC, 2, cycles DAC_DATA/DAC_CH are stable before strobe (>=1)
STROBE_CYC, 1, DAC_WRT high cycles (>=1)
HOLD_CYC, 2, cycles data held after strobe (>=1)
CNT_WIDTH, 8, phase counter width; must hold max(SETUP_CYC, STROBE_CYC, HOLD_CYC)

Ports:
ADC_CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
ARB_EN  in  1  arbiter enable; low blocks new grants
REQ  in  NUM_CH  per-channel write request, level
REQ_DATA  in  NUM_CH*DAC_WIDTH  per-channel data, channel i at bits [i*DAC_WIDTH +: DAC_WIDTH]
ACK  out  NUM_CH  one-cycle completion pulse per channel
DAC_DATA  out  DAC_WIDTH  data to DAC
DAC_CH  out  CH_WIDTH  DAC channel/address select
DAC_WRT  out  1  DAC write strobe, active high
BUSY  out  1  high in any state other than IDLE
XFER_CNT  out  16  completed-transfer counter

Behaviour:
- Reset (async, RST_N low): state IDLE. ACK=0, DAC_DATA=0, DAC_CH=0, DAC_WRT=0, BUSY=0, XFER_CNT=0. Round-robin pointer last_gnt=NUM_CH-1, so channel 0 wins first. Reset mid-transfer aborts immediately with no ACK.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: if ARB_EN=1 and any REQ bit is set, grant the first requesting channel searching last_gnt+1, +2, ... mod NUM_CH.
  - Next edge: DAC_CH=grant, DAC_DATA=REQ_DATA[grant] (sampled once, at grant), last_gnt=grant, -> SETUP.
  - Otherwise stay in IDLE.
- SETUP: DAC_WRT=0 for exactly SETUP_CYC cycles, then -> STROBE.
- STROBE: DAC_WRT=1 for exactly STROBE_CYC cycles, then -> HOLD.
- HOLD: DAC_WRT=0 for HOLD_CYC cycles. ACK[grant]=1 during the last HOLD cycle only. XFER_CNT increments on that same edge, wrapping 0xFFFF->0x0000. Then -> IDLE.
- DAC_DATA and DAC_CH hold their values from grant through IDLE until the next grant. They change only on a grant edge.
- Latency: REQ seen high in IDLE at edge t gives the SETUP entry edge t+1, DAC_WRT rising at t+1+SETUP_CYC, and ACK high in the cycle beginning t+SETUP_CYC+STROBE_CYC+HOLD_CYC. At least one IDLE cycle separates transfers, so the period is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Handshake:
  - A requester holds REQ until it sees ACK.
  - REQ still high in the cycle after ACK counts as a new request, but loses to other pending channels under round robin.
  - REQ dropping after grant does not abort the transfer.
  - REQ dropping before grant means no transfer.
  - REQ_DATA changes after grant are ignored.
- Simultaneous requests: round robin from last_gnt+1. All channels requesting continuously are served 0,1,2,0,1,2...
- ARB_EN low during a transfer: the current transfer completes with ACK. The arbiter then stays in IDLE until ARB_EN returns high. Requests are not lost, since they are levels.
- REQ bits at indices >= NUM_CH do not exist. The pointer wraps strictly modulo NUM_CH.
- At most one ACK bit is high in any cycle. DAC_WRT is never high in IDLE, SETUP or HOLD.

Test Plan:
- Reset then single request: REQ=3'b010, REQ_DATA ch1=14'h1A5C, defaults. Expect grant next edge, DAC_CH=1, DAC_DATA=14'h1A5C, DAC_WRT high exactly 1 cycle starting 3 cycles after REQ edge, ACK=3'b010 one cycle, XFER_CNT=1, BUSY low afterwards.
- All three REQ high continuously for 9 transfers: expect grant order 0,1,2,0,1,2,0,1,2, ACKs spaced exactly 6 cycles apart, XFER_CNT=9.
- REQ_DATA[ch0] changed from 14'h0001 to 14'h3FFF one cycle after grant: expect DAC_DATA stays 14'h0001 through ACK. REQ[2] dropped during STROBE: transfer still completes with ACK[2].
- ARB_EN deasserted during SETUP of ch2 with REQ[0] pending: ch2 completes and ACKs, no further DAC_WRT while ARB_EN=0. On re-enable, ch0 is granted on the next edge.
- RST_N asserted asynchronously mid-STROBE: DAC_WRT, ACK and BUSY fall immediately without waiting for a clock edge. After release, first grant goes to ch0 when REQ=3'b111.
- Preload XFER_CNT to 16'hFFFF via 65535 transfers (or force) and do one more transfer: XFER_CNT reads 16'h0000.
